// File: rtl/qmem_arbiter_rr_if.sv
// qmem bus bundle between N masters and one shared slave, as seen by the arbiter.
// The slave modport is the arbiter; the master modport is the surrounding system.
interface qmem_arbiter_rr_if #(
    parameter int QAW = 32,
    parameter int QDW = 32,
    parameter int QSW = QDW/8,
    parameter int MN  = 2
);
    logic [MN-1:0]     qm_cs;
    logic [MN-1:0]     qm_we;
    logic [MN*QSW-1:0] qm_sel;
    logic [MN*QAW-1:0] qm_adr;
    logic [MN*QDW-1:0] qm_dat_w;
    logic [MN*QDW-1:0] qm_dat_r;
    logic [MN-1:0]     qm_ack;
    logic [MN-1:0]     qm_err;

    logic              qs_cs;
    logic              qs_we;
    logic [QSW-1:0]    qs_sel;
    logic [QAW-1:0]    qs_adr;
    logic [QDW-1:0]    qs_dat_w;
    logic [QDW-1:0]    qs_dat_r;
    logic              qs_ack;
    logic              qs_err;

    modport slave (
        input  qm_cs, qm_we, qm_sel, qm_adr, qm_dat_w,
        output qm_dat_r, qm_ack, qm_err,
        output qs_cs, qs_we, qs_sel, qs_adr, qs_dat_w,
        input  qs_dat_r, qs_ack, qs_err
    );

    modport master (
        output qm_cs, qm_we, qm_sel, qm_adr, qm_dat_w,
        input  qm_dat_r, qm_ack, qm_err,
        input  qs_cs, qs_we, qs_sel, qs_adr, qs_dat_w,
        output qs_dat_r, qs_ack, qs_err
    );
endinterface

// File: rtl/qmem_arbiter_rr.sv
// N-master to 1-slave qmem arbiter, fixed-priority or round-robin, with a grant held
// until the slave terminates the transfer and an optional no-response watchdog.
module qmem_arbiter_rr #(
    parameter int QAW = 32,
    parameter int QDW = 32,
    parameter int QSW = QDW/8,
    parameter int MN  = 2,
    parameter int RR  = 1,
    parameter int TO  = 0,
    parameter int TW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    qmem_arbiter_rr_if.slave bus,
    output logic [MN-1:0] ms,
    output logic          tmo
);
    localparam int LW = (MN > 1) ? $clog2(MN) : 1;
    localparam logic [TW-1:0] TO_CNT = TW'(TO);

    logic [MN-1:0] ms_reg;
    logic [MN-1:0] ms_new;
    logic [LW-1:0] last;
    logic [LW-1:0] ms_idx;
    logic [TW-1:0] cnt;
    logic          tmo_i;
    logic          term;

    // Walk the candidates from farthest to nearest so the nearest requester wins.
    always_comb begin
        logic [LW-1:0] idx;
        idx    = '0;
        ms_new = '0;
        for (int k = MN-1; k >= 0; k--) begin
            if (RR != 0)
                idx = LW'((int'(last) + 1 + k) % MN);
            else
                idx = LW'(k);
            if (bus.qm_cs[idx]) begin
                ms_new      = '0;
                ms_new[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        if (!rst)
            ms = '0;
        else if (ms_reg != '0)
            ms = ms_reg;
        else
            ms = ms_new;
    end

    always_comb begin
        ms_idx = '0;
        for (int i = 0; i < MN; i++)
            if (ms[i]) ms_idx = LW'(i);
    end

    always_comb begin
        bus.qs_cs    = 1'b0;
        bus.qs_we    = 1'b0;
        bus.qs_sel   = '0;
        bus.qs_adr   = '0;
        bus.qs_dat_w = '0;
        for (int i = 0; i < MN; i++) begin
            if (ms[i]) begin
                bus.qs_cs    = bus.qm_cs[i];
                bus.qs_we    = bus.qm_we[i];
                bus.qs_sel   = bus.qm_sel[QSW*i +: QSW];
                bus.qs_adr   = bus.qm_adr[QAW*i +: QAW];
                bus.qs_dat_w = bus.qm_dat_w[QDW*i +: QDW];
            end
        end
    end

    // A real slave response in the same cycle always beats the watchdog.
    assign tmo_i = (TO != 0) && (ms != '0) && (cnt == TO_CNT) && !bus.qs_ack && !bus.qs_err;
    assign term  = bus.qs_ack | bus.qs_err | tmo_i;
    assign tmo   = tmo_i;

    assign bus.qm_dat_r = {MN{bus.qs_dat_r}};
    assign bus.qm_ack   = ms & {MN{bus.qs_ack}};
    assign bus.qm_err   = ms & {MN{bus.qs_err | tmo_i}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            ms_reg <= '0;
            last   <= LW'(MN-1);
            cnt    <= '0;
        end else begin
            if (term)
                ms_reg <= '0;
            else if (ms_reg == '0)
                ms_reg <= ms_new;

            if (term && (ms != '0))
                last <= ms_idx;

            if ((ms == '0) || term)
                cnt <= '0;
            else if (cnt != TO_CNT)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_qmem_arbiter_rr.sv
// Bench for qmem_arbiter_rr: a round-robin/watchdog instance and a fixed-priority
// instance share one stimulus and are compared against a transaction-level model.
module tb_qmem_arbiter_rr;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  cs;
    logic [2:0]  we;
    logic [11:0] sel;
    logic [95:0] adr;
    logic [95:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic        fix_adr;

    qmem_arbiter_rr_if #(.QAW(32), .QDW(32), .QSW(4), .MN(3)) bus_a ();
    qmem_arbiter_rr_if #(.QAW(32), .QDW(32), .QSW(4), .MN(3)) bus_b ();

    logic [2:0] ms_a, ms_b;
    logic       tmo_a, tmo_b;

    assign bus_a.qm_cs = cs;    assign bus_b.qm_cs = cs;
    assign bus_a.qm_we = we;    assign bus_b.qm_we = we;
    assign bus_a.qm_sel = sel;  assign bus_b.qm_sel = sel;
    assign bus_a.qm_adr = adr;  assign bus_b.qm_adr = adr;
    assign bus_a.qm_dat_w = dat_w; assign bus_b.qm_dat_w = dat_w;
    assign bus_a.qs_dat_r = dat_r; assign bus_b.qs_dat_r = dat_r;
    assign bus_a.qs_ack = ack;  assign bus_b.qs_ack = ack;
    assign bus_a.qs_err = err;  assign bus_b.qs_err = err;

    qmem_arbiter_rr #(.QAW(32), .QDW(32), .QSW(4), .MN(3), .RR(1), .TO(8), .TW(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .ms(ms_a), .tmo(tmo_a)
    );
    qmem_arbiter_rr #(.QAW(32), .QDW(32), .QSW(4), .MN(3), .RR(0), .TO(0), .TW(8)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .ms(ms_b), .tmo(tmo_b)
    );

    // Model: owner of the bus (-1 idle), last finished master, cycles spent in the grant.
    int   own[2];
    int   lst[2];
    int   age[2];
    int   e_cur[2];
    logic e_tmo[2];
    int   rr_of[2];
    int   to_of[2];
    int   passed = 0;
    int   total  = 0;

    function automatic int pick(input int d);
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (rr_of[d] != 0) ? (lst[d] + 1 + k) % 3 : k;
            if (cs[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic checkValue(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [2:0] c, input logic a, input logic e, input logic r);
        @(negedge clk);
        cs    = c;
        ack   = a;
        err   = e;
        rst   = r;
        we    = 3'($urandom);
        sel   = 12'($urandom);
        adr   = {$urandom, $urandom, $urandom};
        dat_w = {$urandom, $urandom, $urandom};
        dat_r = $urandom;
        if (fix_adr) adr[63:32] = 32'h40;
        #1;
    endtask

    task automatic checkOutput();
        for (int d = 0; d < 2; d++) begin
            logic [2:0]  o_ms, o_ack, o_err, e_ms, e_ack, e_err;
            logic        o_tmo;
            logic [69:0] o_bus, e_bus;
            logic [95:0] o_dr;
            int          cur;
            if (d == 0) begin
                o_ms = ms_a; o_ack = bus_a.qm_ack; o_err = bus_a.qm_err; o_tmo = tmo_a;
                o_bus = {bus_a.qs_cs, bus_a.qs_we, bus_a.qs_sel, bus_a.qs_adr, bus_a.qs_dat_w};
                o_dr = bus_a.qm_dat_r;
            end else begin
                o_ms = ms_b; o_ack = bus_b.qm_ack; o_err = bus_b.qm_err; o_tmo = tmo_b;
                o_bus = {bus_b.qs_cs, bus_b.qs_we, bus_b.qs_sel, bus_b.qs_adr, bus_b.qs_dat_w};
                o_dr = bus_b.qm_dat_r;
            end
            if (!rst)
                cur = -1;
            else if (own[d] >= 0)
                cur = own[d];
            else
                cur = pick(d);
            e_cur[d] = cur;
            e_tmo[d] = rst && (to_of[d] != 0) && (cur >= 0) && (age[d] == to_of[d]) && !ack && !err;
            e_ms  = (cur >= 0) ? 3'(1 << cur) : 3'b000;
            e_bus = (cur >= 0) ? {cs[cur], we[cur], sel[cur*4 +: 4], adr[cur*32 +: 32], dat_w[cur*32 +: 32]} : '0;
            e_ack = ack ? e_ms : 3'b000;
            e_err = (err || e_tmo[d]) ? e_ms : 3'b000;
            checkValue($sformatf("ms_%0d", d), 128'(o_ms), 128'(e_ms));
            checkValue($sformatf("qm_ack_%0d", d), 128'(o_ack), 128'(e_ack));
            checkValue($sformatf("qm_err_%0d", d), 128'(o_err), 128'(e_err));
            checkValue($sformatf("tmo_%0d", d), 128'(o_tmo), 128'(e_tmo[d]));
            checkValue($sformatf("qs_bus_%0d", d), 128'(o_bus), 128'(e_bus));
            checkValue($sformatf("qm_dat_r_%0d", d), 128'(o_dr), 128'({3{dat_r}}));
        end
    endtask

    task automatic advanceClock();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                own[d] = -1; lst[d] = 2; age[d] = 0;
            end else if (e_cur[d] >= 0 && (ack || err || e_tmo[d])) begin
                lst[d] = e_cur[d]; own[d] = -1; age[d] = 0;
            end else if (e_cur[d] >= 0) begin
                own[d] = e_cur[d];
                age[d] = (age[d] + 1 > to_of[d]) ? to_of[d] : age[d] + 1;
            end else begin
                own[d] = -1; age[d] = 0;
            end
        end
    endtask

    initial begin
        logic [2:0] rr_seq[4];
        rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
        rr_of = '{1, 0};
        to_of = '{8, 0};
        for (int d = 0; d < 2; d++) begin own[d] = -1; lst[d] = 2; age[d] = 0; end
        rst = 1'b0; cs = '0; ack = 1'b0; err = 1'b0; fix_adr = 1'b0;
        $display("[TB] start");

        // Reset with requests and responses present: nothing may leak through.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(3'b111, 1'b1, 1'(i), 1'b0); checkOutput();
            checkValue("rst_ms", 128'({ms_a, ms_b}), 128'(0));
            checkValue("rst_qs_cs", 128'({bus_a.qs_cs, bus_b.qs_cs}), 128'(0));
            checkValue("rst_ack", 128'({bus_a.qm_ack, bus_b.qm_ack}), 128'(0));
            advanceClock();
        end

        // All three request, one-cycle acks: rotate in A, master 0 always in B.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b111, 1'b1, 1'b0, 1'b1); checkOutput();
            checkValue("rr_order", 128'(ms_a), 128'(rr_seq[i]));
            checkValue("rr_ack", 128'(bus_a.qm_ack), 128'(rr_seq[i]));
            checkValue("fp_all", 128'(ms_b), 128'(3'b001));
            advanceClock();
        end

        // Fixed priority never reaches master 2 while master 1 keeps requesting.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b110, 1'b1, 1'b0, 1'b1); checkOutput();
            checkValue("fp_110", 128'(ms_b), 128'(3'b010));
            advanceClock();
        end

        // Master 1 waits three cycles for its ack while master 0 starts requesting.
        fix_adr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i == 0) ? 3'b010 : 3'b011, 1'(i == 3), 1'b0, 1'b1); checkOutput();
            checkValue("hold_ms", 128'({ms_a, ms_b}), 128'(6'b010_010));
            checkValue("hold_adr", 128'({bus_a.qs_adr, bus_b.qs_adr}), 128'(64'h40_0000_0040));
            advanceClock();
        end
        fix_adr = 1'b0;
        applyStimulus(3'b001, 1'b1, 1'b0, 1'b1); checkOutput();
        checkValue("next_grant", 128'({ms_a, ms_b}), 128'(6'b001_001));
        advanceClock();

        // Silent slave: watchdog fires on the ninth granted cycle in A only.
        for (int k = 0; k <= 8; k++) begin
            applyStimulus(3'b001, 1'b0, 1'b0, 1'b1); checkOutput();
            checkValue("wd_tmo", 128'(tmo_a), 128'(k == 8));
            checkValue("wd_err", 128'(bus_a.qm_err), 128'((k == 8) ? 3'b001 : 3'b000));
            checkValue("wd_ack", 128'(bus_a.qm_ack), 128'(0));
            advanceClock();
        end
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b1); checkOutput();
        checkValue("wd_free", 128'(ms_a), 128'(0));
        checkValue("fp_no_wd", 128'(ms_b), 128'(3'b001));
        advanceClock();
        applyStimulus(3'b000, 1'b1, 1'b0, 1'b1); checkOutput(); advanceClock();

        // Ack lands exactly when the watchdog would expire: the ack wins.
        for (int k = 0; k <= 8; k++) begin
            applyStimulus(3'b001, 1'(k == 8), 1'b0, 1'b1); checkOutput();
            if (k == 8) begin
                checkValue("race_ack", 128'(bus_a.qm_ack), 128'(3'b001));
                checkValue("race_err", 128'(bus_a.qm_err), 128'(0));
                checkValue("race_tmo", 128'(tmo_a), 128'(0));
            end
            advanceClock();
        end

        // Reset during master 2's transfer, then round-robin restarts at master 0.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(3'b100, 1'b0, 1'b0, 1'b1); checkOutput();
            checkValue("m2_grant", 128'(ms_a), 128'(3'b100));
            advanceClock();
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(3'b100, 1'b1, 1'b0, 1'b0); checkOutput();
            checkValue("abort_ms", 128'(ms_a), 128'(0));
            checkValue("abort_cs", 128'(bus_a.qs_cs), 128'(0));
            checkValue("abort_ack", 128'(bus_a.qm_ack), 128'(0));
            advanceClock();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b111, 1'b1, 1'b0, 1'b1); checkOutput();
            checkValue("restart_rr", 128'(ms_a), 128'(rr_seq[i]));
            advanceClock();
        end

        // Random traffic, alternating busy phases with quiet slave phases.
        for (int n = 0; n < 450; n++) begin
            logic [2:0] c;
            logic       a, e, r;
            logic       quiet;
            quiet = ((n / 30) % 3) == 2;
            c = 3'($urandom_range(0, 7));
            a = quiet ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 99) < 35);
            e = !quiet && ($urandom_range(0, 99) < 5);
            r = ($urandom_range(0, 199) != 0);
            applyStimulus(c, a, e, r); checkOutput(); advanceClock();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/qmem_arbiter_rr.md
# qmem_arbiter_rr

Parametrised N-master to 1-slave arbiter for the qmem bus, sitting between CPU/DMA-style qmem masters and a shared slave such as a memory controller or register bank. It supports fixed-priority or round-robin arbitration. It holds a grant until the slave terminates the transfer, and a watchdog ends any transfer the slave never acknowledges. All request, data and response signals are routed combinationally, so a granted single-cycle transfer has zero added latency.

## Interface
- QAW, 32, address width
- QDW, 32, data width
- QSW, QDW/8, byte-select width
- MN, 2, number of masters (1..8)
- RR, 1, arbitration mode: 0 = fixed priority (master 0 highest), 1 = round-robin
- TO, 0, watchdog limit in cycles; 0 disables the watchdog
- TW, 8, watchdog counter width; must satisfy 2^TW > TO
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-low
- qm_cs / qm_we  in  MN  per-master chip-select / write-enable
- qm_sel  in  MN*QSW  per-master byte selects, master i at [QSW*i +: QSW]
- qm_adr  in  MN*QAW  per-master address
- qm_dat_w  in  MN*QDW  per-master write data
- qm_dat_r  out  MN*QDW  qs_dat_r replicated to every master slot
- qm_ack / qm_err  out  MN  per-master transfer-complete / error
- qs_cs, qs_we, qs_sel, qs_adr, qs_dat_w  out  1,1,QSW,QAW,QDW  selected master's request
- qs_dat_r  in  QDW  slave read data
- qs_ack / qs_err  in  1  slave complete / error
- ms  out  MN  one-hot grant, all-zero when idle
- tmo  out  1  one-cycle pulse when the watchdog terminates a transfer

## Operation
- State: ms_reg (MN one-hot grant), last (index of the last completed master, width clog2(MN) min 1), cnt (TW-bit watchdog).
- Candidate ms_new, computed from qm_cs:
  - RR=0: lowest-index asserted cs wins.
  - RR=1: search starts at index last+1 mod MN and wraps; the first asserted cs wins.
- Grant: ms = ms_reg when ms_reg != 0, else ms_new. ms is forced to 0 while rst is low.
- Slave mux: qs_* = fields of the master at the one-hot ms index. When ms = 0, all qs_* are 0.
- term = qs_ack | qs_err | tmo_i.
- tmo_i = (TO != 0) & (ms != 0) & (cnt == TO) & ~qs_ack & ~qs_err. A slave response always wins over the watchdog in the same cycle.
- Responses:
  - qm_ack = ms & {MN{qs_ack}}
  - qm_err = ms & {MN{qs_err | tmo_i}}
  - tmo = tmo_i
- ms_reg update (priority order):
  - reset: 0
  - else if term: 0
  - else if ms_reg == 0: ms_new
- last: reset to MN-1, so master 0 is first in round-robin. On term with ms != 0, last <= index(ms). Otherwise it holds. last is unused when RR=0.
- cnt: reset 0. Cleared when ms == 0 or on term; otherwise incremented. Saturates at TO; it never wraps.
- A master dropping cs mid-transfer does not release the grant. qs_cs follows that master's cs (now 0), and the grant persists until term or the watchdog.
- Simultaneous requests in the same cycle resolve per mode. Non-granted masters see no ack, err or tmo.

## Timing
- Reset (rst low at a clock edge): ms_reg=0, last=MN-1, cnt=0. While rst is low: ms=0, qs_cs=0, qm_ack=0, qm_err=0, tmo=0.
- Zero-latency path: cs asserted in cycle n with the slave acking in cycle n gives qm_ack in cycle n. The next grant can start in cycle n+1, so back-to-back transfers have no idle cycle.
- Multi-cycle transfer: the grant is stable from the first request cycle until the term cycle inclusive.
- Watchdog: with the grant first taken in cycle n and no response, cnt equals k at cycle n+k. tmo and qm_err fire in cycle n+TO, and the bus is free in cycle n+TO+1.
- Reset asserted mid-transfer: the grant is dropped at that edge, and no ack or err is generated for the aborted transfer.

## Test plan
- MN=3, RR=0: qm_cs=3'b110 held; slave acks every cycle -> ms=3'b010 every cycle, and master 2 is never granted.
- MN=3, RR=1: qm_cs=3'b111 held, 1-cycle acks from reset -> ms sequence 001, 010, 100, 001; qm_ack matches ms each cycle.
- Master 1 requests adr=0x40, with the slave acking 3 cycles later while master 0 raises cs mid-wait -> ms stays 010 for 4 cycles; master 0 is granted in the following cycle; qs_adr=0x40 throughout.
- TO=8, silent slave, master 0 requests -> tmo and qm_err[0] pulse exactly 8 cycles after grant; qm_ack stays 0; ms=0 in the next cycle if cs is dropped.
- TO=8, qs_ack arrives in the same cycle cnt reaches 8 -> qm_ack=1, qm_err=0, tmo=0.
- rst driven low during a pending transfer of master 2 -> ms=0 and qs_cs=0 from the next edge. After release, the round-robin order restarts at master 0.
